mic1_controlpath: RTL and testbench
===================================

// Module: mic1_controlpath
// PURPOSE
//   Microsequencer of the MIC-1 microarchitecture: holds the microprogram counter (MPC).
//   Computes the next microinstruction address from the MIR address/jump field, the ALU
//   flags N/Z and the MBR byte. Sits between the datapath (flags, MBR) and the control
//   store, which is addressed by MPC and drives MIR.
// PARAMETERS
//   ADDR_W   9   width of MPC and of the MIR NEXT_ADDRESS field
//   MBR_W    8   width of MBR; OR'ed into MPC[MBR_W-1:0] on JMPC
//   RST_ADDR 0   MPC value loaded on reset
// PORTS
//   clk   in   1       single clock; all state updates on rising edge
//   rst   in   1       reset, synchronous, active-low (rst==0 -> reset)
//   N     in   1       ALU negative flag, already registered by datapath
//   Z     in   1       ALU zero flag, already registered by datapath
//   MBR   in   8       memory byte register (opcode) for multiway branch
//   MIR   in   12      MIR[35:24]: [35:27] NEXT_ADDRESS, [26] JMPC, [25] JAMN, [24] JAMZ
//   MPC   out  9       registered microprogram counter, addresses control store
// BEHAVIOUR
//   - One clock domain; reset is synchronous and active-low: posedge clk with rst==0 ->
//     MPC <= RST_ADDR (0); has priority over every other input.
//   - Combinational next address (no state besides MPC):
//       hi     = NEXT_ADDRESS[8] | (JAMN & N) | (JAMZ & Z)
//       lo     = JMPC ? (NEXT_ADDRESS[7:0] | MBR) : NEXT_ADDRESS[7:0]
//       mpc_nx = {hi, lo}
//   - posedge clk with rst==1: MPC <= mpc_nx. Latency exactly one cycle from MIR/N/Z/MBR
//     change to MPC update; MPC is stable between edges (glitch-free, flop output).
//   - JMPC and JAMN/JAMZ asserted together: both applied (bitwise OR), no priority.
//   - JAMN and JAMZ together: bit 8 set if either condition true.
//   - N/Z ignored when their JAM bit is 0; MBR ignored when JMPC is 0.
//   - OR semantics, never addition: no carry, no wrap-around; bit 8 of NEXT_ADDRESS
//     already 1 stays 1 regardless of flags.
//   - Reset asserted mid-operation: next edge forces MPC=0 regardless of MIR; first edge
//     after rst returns to 1 resumes normal sequencing from mpc_nx.
//   - X on unused inputs (N/Z with JAM off, MBR with JMPC off) must not propagate to MPC.
//   - No handshake; control store assumed combinational read of MPC within one cycle.
// STRUCTURE
//   - Shared package mic1_pkg: ADDR_W, MBR_W, MIR field bit positions (MIR_NEXT_HI=35,
//     MIR_NEXT_LO=27, MIR_JMPC=26, MIR_JAMN=25, MIR_JAMZ=24), typedef mpc_t.
//   - One sub-module mic1_next_addr (pure combinational mpc_nx logic); top holds only the
//     MPC register and reset.
// TESTING
//   1. rst=0 for 2 edges, MIR=random -> MPC=0 after first edge; stays 0 while rst=0.
//   2. rst=1, NEXT_ADDRESS=0x005, jumps 0 -> MPC=0x005 after one edge; N=Z=1 no effect.
//   3. NEXT_ADDRESS=0x092, JAMZ=1: Z=1 -> MPC=0x192; Z=0 -> MPC=0x092; same for JAMN/N.
//   4. NEXT_ADDRESS=0x000, JMPC=1, MBR=0x60 -> MPC=0x060; NEXT=0x100, MBR=0x0F -> 0x10F.
//   5. JMPC=1, JAMN=1, N=1, NEXT=0x001, MBR=0x80 -> MPC=0x181 (both applied, OR not add).
//   6. Normal sequencing, then rst=0 for one edge -> MPC=0; rst=1 -> next edge follows MIR.

Source files
------------

// File: rtl/mic1_pkg.sv
// rtl/mic1_pkg.sv - shared widths and MIR field positions for the MIC-1 microsequencer
package mic1_pkg;

    localparam int ADDR_W = 9;
    localparam int MBR_W  = 8;

    localparam int MIR_NEXT_HI = 35;
    localparam int MIR_NEXT_LO = 27;
    localparam int MIR_JMPC    = 26;
    localparam int MIR_JAMN    = 25;
    localparam int MIR_JAMZ    = 24;

    // Only MIR[35:24] reaches the sequencer, so fields are re-based to JAMZ at bit 0.
    localparam int MIR_W = MIR_NEXT_HI - MIR_JAMZ + 1;

    typedef logic [ADDR_W-1:0] mpc_t;

endpackage

// File: rtl/mic1_next_addr.sv
// rtl/mic1_next_addr.sv - combinational next-MPC logic (JAMN/JAMZ on MSB, JMPC OR of MBR)
module mic1_next_addr
    import mic1_pkg::*;
#(
    parameter int ADDR_W = mic1_pkg::ADDR_W,
    parameter int MBR_W  = mic1_pkg::MBR_W
) (
    input  logic [ADDR_W+2:0] mir_i,
    input  logic              n_i,
    input  logic              z_i,
    input  logic [MBR_W-1:0]  mbr_i,
    output logic [ADDR_W-1:0] mpc_nx_o
);

    localparam int NEXT_B = MIR_NEXT_LO - MIR_JAMZ;
    localparam int JMPC_B = MIR_JMPC - MIR_JAMZ;
    localparam int JAMN_B = MIR_JAMN - MIR_JAMZ;
    localparam int JAMZ_B = 0;

    logic [ADDR_W-1:0] next_addr;
    logic              jam_hit;
    logic [MBR_W-1:0]  mbr_gated;

    // Flags and MBR are AND-gated by their enables so an X on an unused input stays out of MPC.
    always_comb begin
        next_addr = mir_i[NEXT_B +: ADDR_W];
        jam_hit   = (mir_i[JAMN_B] & n_i) | (mir_i[JAMZ_B] & z_i);
        mbr_gated = mbr_i & {MBR_W{mir_i[JMPC_B]}};
        mpc_nx_o  = next_addr;
        mpc_nx_o[ADDR_W-1]  = next_addr[ADDR_W-1] | jam_hit;
        mpc_nx_o[MBR_W-1:0] = next_addr[MBR_W-1:0] | mbr_gated;
    end

endmodule

// File: rtl/mic1_controlpath.sv
// rtl/mic1_controlpath.sv - MIC-1 microsequencer: registered MPC fed by mic1_next_addr
module mic1_controlpath
    import mic1_pkg::*;
#(
    parameter int ADDR_W   = mic1_pkg::ADDR_W,
    parameter int MBR_W    = mic1_pkg::MBR_W,
    parameter int RST_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              N,
    input  logic              Z,
    input  logic [MBR_W-1:0]  MBR,
    input  logic [ADDR_W+2:0] MIR,
    output logic [ADDR_W-1:0] MPC
);

    localparam logic [ADDR_W-1:0] RST_MPC = ADDR_W'(RST_ADDR);

    logic [ADDR_W-1:0] mpc_d;
    logic [ADDR_W-1:0] mpc_q;

    mic1_next_addr #(
        .ADDR_W (ADDR_W),
        .MBR_W  (MBR_W)
    ) u_next_addr (
        .mir_i    (MIR),
        .n_i      (N),
        .z_i      (Z),
        .mbr_i    (MBR),
        .mpc_nx_o (mpc_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            mpc_q <= RST_MPC;
        end else begin
            mpc_q <= mpc_d;
        end
    end

    assign MPC = mpc_q;

endmodule

// File: tb/tb_mic1_controlpath.sv
// tb/tb_mic1_controlpath.sv - scoreboard bench for mic1_controlpath against a reference model
module tb_mic1_controlpath;

    logic        clk;
    logic        rst;
    logic        n_in;
    logic        z_in;
    logic [7:0]  mbr;
    logic [11:0] mir;
    logic [8:0]  mpc;

    typedef struct {
        int    exp;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    mic1_controlpath dut (
        .clk (clk),
        .rst (rst),
        .N   (n_in),
        .Z   (z_in),
        .MBR (mbr),
        .MIR (mir),
        .MPC (mpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_mpc(input bit r, input int next, input bit jmpc, input bit jamn,
                                   input bit jamz, input bit nf, input bit zf, input int mbyte);
        int addr;
        if (!r) return 0;
        addr = next;
        if (jmpc) addr = addr | mbyte;
        if ((jamn && nf) || (jamz && zf)) addr = addr | 256;
        return addr;
    endfunction

    task automatic apply(input bit r, input int next, input bit jmpc, input bit jamn,
                         input bit jamz, input logic nf, input logic zf, input int mbyte,
                         input string name);
        exp_t e;
        @(negedge clk);
        rst  = r;
        mir  = {next[8:0], jmpc, jamn, jamz};
        n_in = nf;
        z_in = zf;
        mbr  = mbyte[7:0];
        e.exp  = ref_mpc(r, next, jmpc, jamn, jamz, (nf === 1'b1), (zf === 1'b1), mbyte);
        e.name = name;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (int'(mpc) === e.exp) n_pass++;
            else $display("FAIL %s: MPC=0x%03h required 0x%03h", e.name, mpc, e.exp[8:0]);
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst  = 1'b0;
        mir  = '0;
        n_in = 1'b0;
        z_in = 1'b0;
        mbr  = '0;

        apply(0, int'($urandom_range(511)), 1, 1, 1, 1, 1, 8'hff, "reset_edge1");
        apply(0, int'($urandom_range(511)), 1, 1, 1, 1, 1, 8'hff, "reset_edge2");

        apply(1, 9'h005, 0, 0, 0, 1, 1, 8'hff, "plain_next");
        apply(1, 9'h092, 0, 0, 1, 0, 1, 8'h00, "jamz_z1");
        apply(1, 9'h092, 0, 0, 1, 0, 0, 8'h00, "jamz_z0");
        apply(1, 9'h092, 0, 1, 0, 1, 0, 8'h00, "jamn_n1");
        apply(1, 9'h092, 0, 1, 0, 0, 0, 8'h00, "jamn_n0");
        apply(1, 9'h092, 0, 1, 1, 0, 1, 8'h00, "jamn_jamz_zonly");
        apply(1, 9'h092, 0, 0, 0, 1'bx, 1'bx, 8'hx, "x_on_unused");
        apply(1, 9'h000, 1, 0, 0, 0, 0, 8'h60, "jmpc_60");
        apply(1, 9'h100, 1, 0, 0, 0, 0, 8'h0f, "jmpc_10f");
        apply(1, 9'h001, 1, 1, 0, 1, 0, 8'h80, "jmpc_jamn_or");
        apply(1, 9'h1ff, 1, 1, 1, 1, 1, 8'hff, "all_ones_no_wrap");
        apply(1, 9'h155, 1, 0, 0, 0, 0, 8'h2a, "or_not_add");
        apply(1, 9'h100, 0, 1, 1, 0, 0, 8'h00, "msb_kept");

        apply(1, 9'h033, 0, 0, 0, 0, 0, 8'h00, "seq_a");
        apply(0, 9'h1c4, 1, 1, 1, 1, 1, 8'h3c, "mid_reset");
        apply(1, 9'h044, 0, 0, 1, 0, 1, 8'h00, "resume");

        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(15) != 0), int'($urandom_range(511)), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(255)), "random");
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: pending=%0d required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
